// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - request, response and memory-side signal bundle for dmem_access_ctrl
interface dmem_access_ctrl_if #(
    parameter int MEM_SIZE    = 1024,
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32
);
    localparam int MEM_AW = $clog2(MEM_SIZE);

    logic                   i_cpu_req;
    logic                   i_cpu_we;
    logic [1:0]             i_cpu_size;
    logic                   i_cpu_unsigned;
    logic [ADDR_LENGTH-1:0] i_cpu_addr;
    logic [DATA_LENGTH-1:0] i_cpu_wdata;
    logic [DATA_LENGTH-1:0] o_cpu_rdata;
    logic                   o_cpu_ack;
    logic                   o_cpu_err;

    logic                   i_dbg_req;
    logic [ADDR_LENGTH-1:0] i_dbg_addr;
    logic [DATA_LENGTH-1:0] o_dbg_rdata;
    logic                   o_dbg_ack;

    logic                   o_busy;

    logic [MEM_AW-1:0]      o_m_addr;
    logic                   o_m_rd;
    logic                   o_m_wr;
    logic [DATA_LENGTH-1:0] o_m_wdata;
    logic [DATA_LENGTH-1:0] i_m_rdata;

    modport slave (
        input  i_cpu_req, i_cpu_we, i_cpu_size, i_cpu_unsigned, i_cpu_addr, i_cpu_wdata,
        output o_cpu_rdata, o_cpu_ack, o_cpu_err,
        input  i_dbg_req, i_dbg_addr,
        output o_dbg_rdata, o_dbg_ack,
        output o_busy,
        output o_m_addr, o_m_rd, o_m_wr, o_m_wdata,
        input  i_m_rdata
    );

    modport master (
        output i_cpu_req, i_cpu_we, i_cpu_size, i_cpu_unsigned, i_cpu_addr, i_cpu_wdata,
        input  o_cpu_rdata, o_cpu_ack, o_cpu_err,
        output i_dbg_req, i_dbg_addr,
        input  o_dbg_rdata, o_dbg_ack,
        input  o_busy,
        input  o_m_addr, o_m_rd, o_m_wr, o_m_wdata,
        output i_m_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - CPU/debug arbiter and RMW sequencer in front of a word-wide data memory
module dmem_access_ctrl #(
    parameter int MEM_SIZE    = 1024,
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    dmem_access_ctrl_if.slave     bus
);
    localparam int MEM_AW = $clog2(MEM_SIZE);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        ACK
    } state_t;

    state_t state;
    state_t state_nxt;

    // transaction context latched at grant
    logic        lat_cpu;
    logic        lat_we;
    logic        lat_uns;
    logic [1:0]  lat_size;
    logic [1:0]  lat_lane;
    logic [15:0] lat_sub_wdata;

    logic [MEM_AW-1:0]      m_addr;
    logic                   m_rd;
    logic                   m_wr;
    logic [DATA_LENGTH-1:0] m_wdata;
    logic [DATA_LENGTH-1:0] cpu_rdata;
    logic                   cpu_ack;
    logic                   cpu_err;
    logic [DATA_LENGTH-1:0] dbg_rdata;
    logic                   dbg_ack;
    logic                   busy;

    logic grant_cpu;
    logic grant_dbg;
    logic in_half;
    logic in_word;
    logic in_misaligned;
    logic cpu_ack_nxt;
    logic dbg_ack_nxt;
    logic lat_half;
    logic lat_word;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_cpu_addr[ADDR_LENGTH-1:MEM_AW+2],
                                bus.i_dbg_addr[ADDR_LENGTH-1:MEM_AW]};

    assign grant_cpu     = bus.i_cpu_req;
    assign grant_dbg     = !bus.i_cpu_req && bus.i_dbg_req;
    assign in_half       = (bus.i_cpu_size == SZ_HALF);
    assign in_word       = bus.i_cpu_size[1];
    assign in_misaligned = (in_half && bus.i_cpu_addr[0]) ||
                           (in_word && (bus.i_cpu_addr[1:0] != 2'b00));
    assign lat_half      = (lat_size == SZ_HALF);
    assign lat_word      = lat_size[1];

    function automatic logic [31:0] merge_store(
        input logic [31:0] word,
        input logic [15:0] data,
        input logic [1:0]  lane,
        input logic        half
    );
        logic [31:0] r;
        r = word;
        if (half) begin
            if (lane[1]) r[31:16] = data;
            else         r[15:0]  = data;
        end else begin
            case (lane)
                2'd0:    r[7:0]   = data[7:0];
                2'd1:    r[15:8]  = data[7:0];
                2'd2:    r[23:16] = data[7:0];
                default: r[31:24] = data[7:0];
            endcase
        end
        return r;
    endfunction

    function automatic logic [31:0] extend_load(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic        half,
        input logic        whole,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        if (whole)     return word;
        else if (half) return uns ? {16'h0000, h} : {{16{h[15]}}, h};
        else           return uns ? {24'h000000, b} : {{24{b[7]}}, b};
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_cpu) begin
                    if (in_misaligned)                 state_nxt = ACK;
                    else if (bus.i_cpu_we && in_word)  state_nxt = WR;
                    else                               state_nxt = RD;
                end else if (grant_dbg) begin
                    state_nxt = RD;
                end
            end
            RD:      state_nxt = WAIT;
            WAIT:    state_nxt = (lat_cpu && lat_we) ? WR : ACK;
            WR:      state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // only a misaligned CPU access goes straight from IDLE to ACK
    assign cpu_ack_nxt = (state_nxt == ACK) && ((state == IDLE) || lat_cpu);
    assign dbg_ack_nxt = (state_nxt == ACK) && (state != IDLE) && !lat_cpu;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lat_cpu       <= 1'b0;
            lat_we        <= 1'b0;
            lat_uns       <= 1'b0;
            lat_size      <= 2'b00;
            lat_lane      <= 2'b00;
            lat_sub_wdata <= '0;
            m_addr        <= '0;
            m_rd          <= 1'b0;
            m_wr          <= 1'b0;
            m_wdata       <= '0;
            cpu_rdata     <= '0;
            cpu_ack       <= 1'b0;
            cpu_err       <= 1'b0;
            dbg_rdata     <= '0;
            dbg_ack       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            m_rd    <= (state_nxt == RD) || (state_nxt == WAIT);
            m_wr    <= (state_nxt == WR);
            busy    <= (state_nxt != IDLE);
            cpu_ack <= cpu_ack_nxt;
            dbg_ack <= dbg_ack_nxt;
            cpu_err <= (state == IDLE) && grant_cpu && in_misaligned;

            case (state)
                IDLE: begin
                    if (grant_cpu) begin
                        lat_cpu       <= 1'b1;
                        lat_we        <= bus.i_cpu_we;
                        lat_uns       <= bus.i_cpu_unsigned;
                        lat_size      <= bus.i_cpu_size;
                        lat_lane      <= bus.i_cpu_addr[1:0];
                        lat_sub_wdata <= bus.i_cpu_wdata[15:0];
                        m_addr        <= bus.i_cpu_addr[MEM_AW+1:2];
                        if (in_misaligned)
                            cpu_rdata <= '0;
                        else if (bus.i_cpu_we && in_word)
                            m_wdata   <= bus.i_cpu_wdata;
                    end else if (grant_dbg) begin
                        lat_cpu  <= 1'b0;
                        lat_we   <= 1'b0;
                        lat_uns  <= 1'b0;
                        lat_size <= 2'b10;
                        lat_lane <= 2'b00;
                        m_addr   <= bus.i_dbg_addr[MEM_AW-1:0];
                    end
                end
                WAIT: begin
                    // read data is valid at the edge that leaves WAIT
                    if (lat_cpu) begin
                        if (lat_we)
                            m_wdata <= merge_store(bus.i_m_rdata, lat_sub_wdata, lat_lane, lat_half);
                        else
                            cpu_rdata <= extend_load(bus.i_m_rdata, lat_lane, lat_half, lat_word, lat_uns);
                    end else begin
                        dbg_rdata <= bus.i_m_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_m_addr    = m_addr;
    assign bus.o_m_rd      = m_rd;
    assign bus.o_m_wr      = m_wr;
    assign bus.o_m_wdata   = m_wdata;
    assign bus.o_cpu_rdata = cpu_rdata;
    assign bus.o_cpu_ack   = cpu_ack;
    assign bus.o_cpu_err   = cpu_err;
    assign bus.o_dbg_rdata = dbg_rdata;
    assign bus.o_dbg_ack   = dbg_ack;
    assign bus.o_busy      = busy;
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequencing and arbitration controller placed in front of the word-organised data memory.
- Serves two requesters:
  - the pipeline MEM stage (CPU port): byte, halfword and word loads and stores.
  - the debug unit (DBG port): word reads only.
- Sub-word stores use read-modify-write, because the memory only supports whole-word writes.
- The CPU port has fixed priority. A transaction in progress is never preempted.

Parameters:
- MEM_SIZE, 1024, number of 32-bit words in memory. Local MEM_AW = clog2(MEM_SIZE).
- ADDR_LENGTH, 32, width of the CPU byte address and the DBG word address.
- DATA_LENGTH, 32, data width. Fixed at 32; the lane logic assumes 4 bytes per word.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_cpu_req  in  1  CPU request. Held high until o_cpu_ack.
- i_cpu_we  in  1  1 = store, 0 = load.
- i_cpu_size  in  2  00 = byte, 01 = half, 10 = word. 11 is treated as word.
- i_cpu_unsigned  in  1  zero-extend sub-word loads.
- i_cpu_addr  in  ADDR_LENGTH  byte address.
- i_cpu_wdata  in  DATA_LENGTH  store data, right-aligned.
- o_cpu_rdata  out  DATA_LENGTH  load result, extended.
- o_cpu_ack  out  1  one-cycle completion pulse.
- o_cpu_err  out  1  misaligned access, pulses together with ack.
- i_dbg_req  in  1  debug read request. Held until o_dbg_ack.
- i_dbg_addr  in  ADDR_LENGTH  word address.
- o_dbg_rdata  out  DATA_LENGTH  read word.
- o_dbg_ack  out  1  one-cycle completion pulse.
- o_busy  out  1  high whenever the state is not IDLE.
- o_m_addr  out  MEM_AW  memory word index.
- o_m_rd  out  1  memory read strobe.
- o_m_wr  out  1  memory write strobe.
- o_m_wdata  out  DATA_LENGTH  memory write data.
- i_m_rdata  in  DATA_LENGTH  memory read data.

Behaviour:
- Reset:
  - Asynchronous, active-high. Forces state IDLE; all outputs and latched request registers go to 0.
  - Reset mid-transaction aborts it. No o_m_wr pulse follows. An RMW interrupted before state WR leaves memory unchanged.
- States: IDLE, RD, WAIT, WR, ACK. All outputs are registered.
- IDLE:
  - Samples requests at the rising edge.
  - If i_cpu_req is high, the CPU request is granted. Otherwise, if i_dbg_req is high, the DBG request is granted.
  - On grant, the controller latches addr, size, we, unsigned, wdata and the requester id.
- Word index:
  - CPU: addr[MEM_AW+1:2].
  - DBG: addr[MEM_AW-1:0].
  - Upper address bits are ignored, so out-of-range addresses wrap.
- Misaligned CPU access: half with addr[0]=1, or word with addr[1:0]!=0.
  - Transition IDLE→ACK. No memory strobe is issued.
  - o_cpu_err=1 and o_cpu_ack=1 in the ACK cycle; o_cpu_rdata=0.
- Load or DBG read: IDLE→RD→WAIT→ACK.
  - o_m_rd is high during both RD and WAIT.
  - i_m_rdata is captured at the rising edge that ends WAIT.
  - Ack is in the 3rd cycle after the grant edge.
- Word store: IDLE→WR→ACK.
  - o_m_wr is high for exactly one cycle, with o_m_addr and o_m_wdata stable for that whole cycle.
  - Ack is in the 2nd cycle after the grant edge.
- Byte/half store: IDLE→RD→WAIT→WR→ACK.
  - The captured word is merged with the store data: byte lane = addr[1:0] (lane 0 = bits 7:0); half lane = addr[1].
  - The merged word is written in WR. Ack is in the 4th cycle after the grant edge.
- Load extension:
  - The selected byte or half is sign-extended, or zero-extended when i_cpu_unsigned=1.
  - Word loads are returned unmodified. DBG reads are never extended.
- ACK state:
  - Exactly one of o_cpu_ack / o_dbg_ack pulses, for one cycle; the state then returns to IDLE.
  - Requests are not sampled in ACK.
  - A requester must drop req in its ack cycle, otherwise the request is taken as a new transaction at the next IDLE edge.
- Output holding and strobes:
  - o_cpu_rdata and o_dbg_rdata hold their value until the next completion on that port.
  - o_m_rd and o_m_wr are never high together, and both are 0 in IDLE and ACK.
- Simultaneous requests: the CPU wins. DBG is granted at the first IDLE edge where i_cpu_req=0.
- A DBG request arriving mid-CPU-transaction waits, and is not lost provided it is held.

Test Plan:
- Word 3 = 0x8899AABB; CPU LB addr 0x0D signed → o_cpu_rdata=0xFFFFFFAA, ack 3 cycles after grant, no o_m_wr. Same access unsigned → 0x000000AA.
- Word 3 = 0x8899AABB; CPU SB addr 0x0E data 0x11 → word 3 = 0x8811AABB, exactly one o_m_wr pulse, ack 4 cycles after grant. SH addr 0x0C data 0x1234 → 0x88991234.
- CPU SW addr 0x10 data 0xDEADBEEF → o_m_wr for one cycle at index 4, ack 2 cycles after grant. LW addr 0x10 → 0xDEADBEEF.
- CPU and DBG requests (DBG addr 4) raised in the same cycle → CPU completes first; DBG is granted on the next IDLE edge; o_dbg_rdata=0xDEADBEEF.
- CPU LH addr 0x0D → o_cpu_err=1 and o_cpu_ack=1 one cycle after the grant edge; o_m_rd and o_m_wr stay 0.
- SB started, i_rst pulsed during WAIT → all outputs 0 immediately, no o_m_wr, memory unchanged; a subsequent request completes normally.
